// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - N-to-1 write-back arbiter feeding one registered register-file write port.
// WB_ARB_ROUND_ROBIN_EN selects round-robin arbitration; the default build uses fixed lowest-index priority.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  input  logic                      rf_stall,
  output logic [15:0]               wr_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic              stage_free;
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic              transfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]  ptr_q, ptr_d;
`endif

  assign stage_free = !out_valid_q || !rf_stall;

  // Search order starts just after the last winner in round-robin mode, at index 0 otherwise.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      cand = (int'(ptr_q) + 1 + k) % NUM_REQ;
`else
      cand = k;
`endif
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && stage_free && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Address 0 is the hardwired zero register: accept the request but never write it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (stage_free) begin
      out_valid_d = 1'b0;
      if (transfer && (sel_addr != '0)) begin
        out_valid_d = 1'b1;
        out_addr_d  = sel_addr;
        out_data_d  = sel_data;
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (out_valid_q && !rf_stall && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign rf_we    = out_valid_q;
  assign rf_addr  = out_addr_q;
  assign rf_data  = out_data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter.
// Builds against either arbitration mode selected by WB_ARB_ROUND_ROBIN_EN.
module tb_regfile_write_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_addr;
  logic [DATA_W-1:0]         rf_data;
  logic                      rf_stall = 1'b0;
  logic [15:0]               wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .rf_stall(rf_stall), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending write, a grant pointer and a consumed-write counter.
  logic               m_valid;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_data;
  logic [15:0]        m_count;
  int                 m_ptr;
  logic               m_free;
  int                 exp_g;
  logic [NUM_REQ-1:0] exp_ready;

  function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
    logic [NUM_REQ-1:0] sh;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      int idx = (ptr + 1 + k) % NUM_REQ;
`else
      int idx = k;
`endif
      sh = v >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  always_comb begin
    m_free    = !m_valid || !rf_stall;
    exp_g     = model_grant(req_valid, m_ptr);
    exp_ready = '0;
    if (reset && m_free && exp_g >= 0) exp_ready = NUM_REQ'(1) << exp_g;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      m_count <= '0;
      m_ptr   <= NUM_REQ - 1;
    end else begin
      if (m_valid && !rf_stall && m_count != 16'hFFFF) m_count <= m_count + 16'd1;
      if (m_free) begin
        if (exp_g >= 0) begin
          m_ptr <= exp_g;
          if (req_addr[exp_g*ADDR_W +: ADDR_W] != '0) begin
            m_valid <= 1'b1;
            m_addr  <= req_addr[exp_g*ADDR_W +: ADDR_W];
            m_data  <= req_data[exp_g*DATA_W +: DATA_W];
          end else begin
            m_valid <= 1'b0;
          end
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_ready", req_ready, exp_ready);
    check("model_rf_we", rf_we, m_valid);
    if (m_valid) begin
      check("model_rf_addr", rf_addr, m_addr);
      check("model_rf_data", rf_data, m_data);
    end
    check("model_wr_count", wr_count, m_count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  logic [NUM_REQ-1:0] seq_ready [4];
  logic [ADDR_W-1:0]  seq_addr  [4];

  initial begin
`ifdef WB_ARB_ROUND_ROBIN_EN
    seq_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
    seq_addr  = '{5'd1, 5'd2, 5'd3, 5'd1};
`else
    seq_ready = '{3'b001, 3'b001, 3'b001, 3'b001};
    seq_addr  = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
    repeat (2) @(posedge clk);
    #1;
    req_valid = 3'b111;
    #1;
    check("reset_ready", req_ready, 3'b000);
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_addr", rf_addr, 5'd0);
    check("reset_rf_data", rf_data, 32'd0);
    check("reset_wr_count", wr_count, 16'd0);
    req_valid = '0;
    reset = 1'b1;

    // Single write, one-cycle latency.
    tick();
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    check("single_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check("single_rf_we", rf_we, 1'b1);
    check("single_rf_addr", rf_addr, 5'd5);
    check("single_rf_data", rf_data, 32'hDEADBEEF);
    tick();
    check("single_wr_count", wr_count, 16'd1);
    check("single_drain", rf_we, 1'b0);

    // All requesters valid continuously, starting from a fresh reset.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("contend_ready", req_ready, seq_ready[c]);
      tick();
      check("contend_rf_we", rf_we, 1'b1);
      check("contend_rf_addr", rf_addr, seq_addr[c]);
    end
    req_valid = '0;
    tick();
    check("contend_wr_count", wr_count, 16'd4);

    // Stall holds the stage for three cycles.
    set_req(2, 5'd7, 32'h77);
    req_valid = 3'b100;
    tick();
    set_req(0, 5'd4, 32'h44);
    set_req(1, 5'd6, 32'h66);
    req_valid = 3'b011;
    rf_stall  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", req_ready, 3'b000);
      check("stall_rf_we", rf_we, 1'b1);
      check("stall_rf_addr", rf_addr, 5'd7);
      check("stall_wr_count", wr_count, 16'd4);
      tick();
    end
    rf_stall  = 1'b0;
    req_valid = '0;
    tick();
    check("stall_release_count", wr_count, 16'd5);
    check("stall_release_we", rf_we, 1'b0);

    // Address 0 is accepted but never written.
    set_req(1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    #1;
    check("zero_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    check("zero_rf_we", rf_we, 1'b0);
    tick();
    check("zero_wr_count", wr_count, 16'd5);

    // Asynchronous reset while a write is stalled.
    set_req(2, 5'd12, 32'h55);
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    rf_stall  = 1'b1;
    check("prereset_rf_we", rf_we, 1'b1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rf_we", rf_we, 1'b0);
    check("async_ready", req_ready, 3'b000);
    check("async_wr_count", wr_count, 16'd0);
    tick();
    reset    = 1'b1;
    rf_stall = 1'b0;
    check("no_replay_rf_we", rf_we, 1'b0);

    // Two requesters on the same address: later grant's data lands last.
    set_req(0, 5'd9, 32'hAAAA0000);
    set_req(1, 5'd9, 32'hBBBB0000);
    req_valid = 3'b011;
    #1;
    check("post_reset_first_grant", req_ready, 3'b001);
    tick();
    req_valid = 3'b010;
    check("same_addr_first_data", rf_data, 32'hAAAA0000);
    #1;
    check("same_addr_second_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    check("same_addr_last_addr", rf_addr, 5'd9);
    check("same_addr_last_data", rf_data, 32'hBBBB0000);
    tick();
    check("same_addr_wr_count", wr_count, 16'd2);
    check("same_addr_drain", rf_we, 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write-back requesters, range 2..8.
REQ-002 Parameter DATA_W, default 32: register data width.
REQ-003 Parameter ADDR_W, default 5: register address width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_addr  input  NUM_REQ*ADDR_W  per-requester destination register; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 req_data  input  NUM_REQ*DATA_W  per-requester write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  output  NUM_REQ  one-hot-or-zero accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at posedge.
REQ-010 rf_we  output  1  register-file write enable, registered.
REQ-011 rf_addr  output  ADDR_W  register-file write address, registered.
REQ-012 rf_data  output  DATA_W  register-file write data, registered.
REQ-013 rf_stall  input  1  register-file write port blocked this cycle; a held write is not consumed.
REQ-014 wr_count  output  16  saturating count of writes consumed by the register file.

Function
REQ-015 One output stage (out_valid, out_addr, out_data); rf_we = out_valid, rf_addr = out_addr, rf_data = out_data, all driven straight from flops.
REQ-016 The stage is free when out_valid = 0, or when out_valid = 1 and rf_stall = 0.
REQ-017 The arbiter selects at most one requester per cycle from those with req_valid high; req_ready is high only for the selected requester and only while the stage is free.
REQ-018 req_ready is a combinational function of req_valid, the arbitration pointer, out_valid and rf_stall; it does not depend on req_addr or req_data.
REQ-019 On a transfer with a nonzero address, the stage loads the address and data with out_valid = 1; latency from request to rf_we is 1 cycle.
REQ-020 On a transfer with address 0, the requester is still accepted, but the stage is not loaded (out_valid = 0 next cycle unless refilled) and wr_count is unchanged.
REQ-021 If the stage drains (rf_stall = 0) and there is no transfer in the same cycle, out_valid = 0 next cycle.
REQ-022 If out_valid = 1 and rf_stall = 1, the stage holds its contents, all req_ready are 0, and the arbitration pointer is frozen.
REQ-023 wr_count increments by 1 on every cycle with out_valid = 1 and rf_stall = 0, and saturates at 16'hFFFF.
REQ-024 If two requesters target the same address in one cycle, they are serialized in grant order, and the later grant's data is the last data written.
REQ-025 rf_* outputs change only at posedge, so they are stable at the register file's negedge write edge.
REQ-026 The arbitration pointer updates only on a transfer, to the index just granted.

Reset
REQ-027 While reset = 0, asynchronously: out_valid = 0, out_addr = 0, out_data = 0, wr_count = 0, pointer = NUM_REQ-1.
REQ-028 req_ready is 0 for every requester while reset = 0.
REQ-029 A write held under rf_stall when reset asserts is discarded and is not replayed after reset.

Configuration
REQ-030 Macro WB_ARB_ROUND_ROBIN_EN defined: round-robin arbitration; the search starts at pointer+1 modulo NUM_REQ, so after reset requester 0 has first priority.
REQ-031 Macro WB_ARB_ROUND_ROBIN_EN undefined: fixed priority, where the lowest index with req_valid high wins; the pointer logic is removed and every other requirement is unchanged.

Verification
REQ-032 Reset, then req_valid = 3'b001, addr 5, data 32'hDEADBEEF, rf_stall = 0 -> req_ready[0] = 1 at once; next cycle rf_we = 1, rf_addr = 5, rf_data = DEADBEEF; wr_count = 1.
REQ-033 Round-robin build, all three requesters valid continuously with addrs 1/2/3 -> grants in order 0,1,2,0; one rf_we per cycle; wr_count = 4 after 4 writes.
REQ-034 Fixed-priority build, same stimulus -> requester 0 is granted every cycle, and requesters 1 and 2 never get req_ready.
REQ-035 Stage holds addr 7 and rf_stall is held high for 3 cycles -> rf_we = 1 and addr 7 are stable, req_ready = 0 throughout, and wr_count increments only once, after rf_stall falls.
REQ-036 Requester 1 writes addr 0, data 32'h1234 -> req_ready[1] = 1, rf_we stays 0 the next cycle, and wr_count is unchanged.
REQ-037 Reset pulled low mid-cycle while a write is stalled -> rf_we = 0 immediately, without waiting for a clock edge; after release, the first grant goes to requester 0.
